mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency unified memory between the core's instruction-fetch path and its load/store path.
- Sits between the datapath and the memory. It serialises requests, holds them stable until the memory's ready handshake, and returns read data with a one-cycle acknowledge.
- Provides the stall signal that freezes PC and register-file writes, so the single-cycle datapath can run against slower, shared memory.

Parameters:
- ADDR_W, 64, address width (matches the 64-bit PC and ALUResult).
- DATA_W, 64, data width for both requesters and the memory.
- TIMEOUT, 255, maximum cycles spent waiting for mem_ready before abort; must be at least 1.
- MAX_D_RUN, 4, maximum consecutive data grants allowed while a fetch is pending.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request, held high until if_ack
- if_addr  in  ADDR_W  fetch address (nextPC)
- if_rdata  out  DATA_W  fetched word, valid while if_ack=1
- if_ack  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request, held high until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address (ALUResult)
- d_wdata  in  DATA_W  store data (ReadData2)
- d_rdata  out  DATA_W  load data, valid while d_ack=1
- d_ack  out  1  one-cycle data completion pulse
- mem_req  out  1  memory request, held until mem_ready or timeout
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- mem_ready  in  1  memory completion, sampled only while mem_req=1
- stall  out  1  combinational: (if_req & ~if_ack) | (d_req & ~d_ack)
- err  out  1  sticky timeout flag

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE; all registered outputs 0 (mem_req, mem_we, mem_addr, mem_wdata, if_ack, d_ack, if_rdata, d_rdata, err); counters 0.
  - A transaction in flight is dropped silently; no ack is generated.
- States: IDLE, BUSY_I, BUSY_D, ACK.
- IDLE grant decision (if no request is present, stay in IDLE):
  - d_req=1 and d_run<MAX_D_RUN → latch d_addr/d_wdata/d_we into the mem_* registers, mem_req←1, go to BUSY_D, d_run++.
  - Otherwise if_req=1 → latch if_addr, mem_we←0, mem_req←1, go to BUSY_I, d_run←0.
  - d_req=1 with d_run≥MAX_D_RUN and if_req=0 → grant data and reset d_run to 1.
- BUSY_x:
  - The wait counter increments every cycle.
  - mem_ready=1 → mem_req←0; capture mem_rdata into the owner's rdata (stores capture nothing); go to ACK.
  - wait==TIMEOUT and no mem_ready → mem_req←0, err←1, owner's rdata←0, go to ACK.
- ACK:
  - Owner's ack=1 for exactly one cycle, then return to IDLE and clear the wait counter.
  - A new grant earliest in the following cycle.
- Latency: request seen at cycle N → mem_req at N+1 → ack one cycle after the mem_ready cycle. Minimum is 3 cycles (mem_ready in the first BUSY cycle).
- mem_* outputs are stable for the whole BUSY phase; requester inputs changing mid-transaction have no effect.
- Requester deasserting req before ack: the transaction still completes and the ack still pulses; the requester ignores it.
- Simultaneous if_req and d_req: data wins (it belongs to the executing instruction) unless the starvation limit is reached.
- mem_ready while mem_req=0 is ignored.
- err clears only on reset; the arbiter keeps operating after a timeout.
- Counters saturate and never wrap: wait is 8 bits sized from TIMEOUT; d_run is sized from MAX_D_RUN.

Decomposition:
- Shared package (mem_arb_pkg) holds:
  - state encoding IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2, ACK=2'd3;
  - owner encoding OWN_I/OWN_D;
  - default TIMEOUT and MAX_D_RUN constants.
- Sub-module wait_timer: saturating counter with clear, enable, and terminal-count output. The FSM, mux and output registers stay in mem_port_arbiter.

Test Plan:
- Lone fetch: if_req=1, if_addr=0x40, mem_ready after 2 BUSY cycles with mem_rdata=0x00500093 → mem_addr=0x40, mem_we=0, if_ack one pulse with if_rdata=0x00500093, stall low the cycle after.
- Store then load: d_req, d_we=1, addr 0x100, wdata 0xDEAD; then d_we=0 at 0x100 with memory model returning 0xDEAD → mem_we=1 then 0, d_rdata=0xDEAD, two d_ack pulses.
- Contention: if_req and d_req both high in the same cycle → data granted first, fetch granted after ACK. With d_req held continuously for 5 grants → fetch granted after the 4th.
- Timeout: mem_ready tied low, TIMEOUT=8 → mem_req falls after 8 BUSY cycles, err=1 stays high, ack pulses with rdata=0, next request is serviced normally.
- Reset mid-BUSY_D: assert reset between clock edges → mem_req and all outputs 0 immediately, no d_ack. After release, a new fetch completes normally.
- Spurious mem_ready in IDLE and held-stable check → no ack generated; mem_addr unchanged while d_addr toggles during BUSY.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
// Holds the FSM and owner encodings, default timing limits and a helper
// that sizes saturating counters from their maximum value.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        ACK    = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int TIMEOUT_DEF   = 255;
    localparam int MAX_D_RUN_DEF = 4;

    // Bits needed to hold 0..max_val (at least one bit).
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_wait_timer.sv
// wait_timer: saturating up-counter used to bound the wait for mem_ready.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   clr        : synchronous clear (takes priority over en)
//   en         : count one cycle
//   tc         : high during the LIMIT-th counted cycle and beyond
module wait_timer
    import mem_arb_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int           W   = cnt_w(LIMIT);
    localparam logic [W-1:0] LIM = W'(LIMIT);
    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LIM)) begin
            cnt <= cnt + ONE;
        end
    end

    // cnt holds the number of cycles already waited, so the current cycle is
    // cycle cnt+1; flagging at LIM-1 gives the requester exactly LIMIT cycles.
    assign tc = (cnt >= (LIM - ONE));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, variable-latency memory between
// instruction fetch and load/store. Serialises requests, holds the memory
// request stable until mem_ready (or timeout), returns read data with a
// one-cycle ack, and produces the datapath stall.
// Ports:
//   clk, reset                        : clock, asynchronous active-high reset
//   if_req/if_addr -> if_rdata/if_ack : fetch requester
//   d_req/d_we/d_addr/d_wdata
//                  -> d_rdata/d_ack   : load/store requester
//   mem_req/mem_we/mem_addr/mem_wdata
//                  <- mem_rdata/mem_ready : memory side
//   stall                             : pending request not yet acked
//   err                               : sticky timeout flag
//
// state  | meaning
// IDLE   | no transaction; grant decision made here
// BUSY_I | fetch on the memory bus, waiting for mem_ready or timeout
// BUSY_D | load/store on the memory bus, waiting for mem_ready or timeout
// ACK    | owner's ack high for this one cycle
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int TIMEOUT   = TIMEOUT_DEF,
    parameter int MAX_D_RUN = MAX_D_RUN_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall,
    output logic              err
);

    localparam int               RUN_W   = cnt_w(MAX_D_RUN);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_D_RUN);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

    arb_state_t       state, state_nx;
    owner_t           owner;
    logic [RUN_W-1:0] d_run;
    logic             busy, tmo;
    logic             grant_d, grant_i, done, abort;

    assign busy = (state == BUSY_I) || (state == BUSY_D);

    wait_timer #(.LIMIT(TIMEOUT)) u_wait (
        .clk   (clk),
        .reset (reset),
        .clr   (state == ACK),
        .en    (busy),
        .tc    (tmo)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        grant_d  = 1'b0;
        grant_i  = 1'b0;
        done     = 1'b0;
        abort    = 1'b0;
        case (state)
            IDLE: begin
                // Data wins unless it has hogged the port while a fetch waits;
                // with no fetch waiting, data is granted regardless of the run.
                if (d_req && ((d_run < RUN_MAX) || !if_req)) begin
                    grant_d  = 1'b1;
                    state_nx = BUSY_D;
                end else if (if_req) begin
                    grant_i  = 1'b1;
                    state_nx = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready) begin
                    done     = 1'b1;
                    state_nx = ACK;
                end else if (tmo) begin
                    abort    = 1'b1;
                    state_nx = ACK;
                end
            end
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            err       <= 1'b0;
            owner     <= OWN_I;
            d_run     <= '0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            if (grant_d) begin
                mem_req   <= 1'b1;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                owner     <= OWN_D;
                d_run     <= (d_run < RUN_MAX) ? d_run + RUN_ONE : RUN_ONE;
            end else if (grant_i) begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= if_addr;
                owner    <= OWN_I;
                d_run    <= '0;
            end
            if (done || abort) begin
                mem_req <= 1'b0;
                if (owner == OWN_I) begin
                    if_ack   <= 1'b1;
                    if_rdata <= abort ? '0 : mem_rdata;
                end else begin
                    d_ack <= 1'b1;
                    if (abort)        d_rdata <= '0;
                    else if (!mem_we) d_rdata <= mem_rdata;
                end
            end
            if (abort) err <= 1'b1;
        end
    end

    assign stall = (if_req & ~if_ack) | (d_req & ~d_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we;
    logic [63:0] if_addr, d_addr, d_wdata;
    logic [63:0] if_rdata, d_rdata;
    logic        if_ack, d_ack;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready;
    logic        stall, err;
    logic        rdy_model, rdy_spur;

    always #5 clk = ~clk;

    assign mem_ready = rdy_model | rdy_spur;

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(8), .MAX_D_RUN(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall(stall), .err(err)
    );

    typedef struct { logic [63:0] data; bit chk; } exp_t;

    exp_t exp_i[$];
    exp_t exp_d[$];
    bit   ack_log[$];
    int   errors = 0, checks = 0, n_acks = 0, req_hi = 0;
    int   mem_lat = 2;
    bit   mem_dead = 1'b0;
    int   lat_i_last = 0, lat_d_last = 0;

    localparam logic [63:0] RUN_ADDR [5] = '{64'h200, 64'h208, 64'h210, 64'h218, 64'h220};
    localparam logic [63:0] RUN_DATA [5] = '{64'hA0A0, 64'hB1B1, 64'hC2C2, 64'hD3D3, 64'hE4E4};

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Memory model: answers a request in its mem_lat-th cycle; writes on that cycle.
    initial begin
        logic [63:0] mem_arr [logic [63:0]];
        int mcnt;
        mem_arr[64'h40] = 64'h00500093;
        mem_arr[64'h80] = 64'hF00D;
        for (int k = 0; k < 5; k++) mem_arr[RUN_ADDR[k]] = RUN_DATA[k];
        rdy_model = 1'b0;
        mem_rdata = '0;
        mcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            rdy_model = 1'b0;
            if (mem_req && !mem_dead) begin
                mcnt++;
                if (mcnt == mem_lat) begin
                    rdy_model = 1'b1;
                    mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : 64'h0;
                    if (mem_we) mem_arr[mem_addr] = mem_wdata;
                end
            end else begin
                mcnt = 0;
            end
        end
    end

    // Monitor: pops the expected response whenever an ack is presented.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mem_req) req_hi++;
            if (reset) continue;
            if (if_ack && d_ack) chk1("ack_exclusive", 1'b1, 1'b0);
            if (if_ack) begin
                n_acks++;
                ack_log.push_back(1'b0);
                if (exp_i.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_if_ack: got if_ack=1 required none");
                end else begin
                    e = exp_i.pop_front();
                    if (e.chk) chk64("if_rdata", if_rdata, e.data);
                end
            end
            if (d_ack) begin
                n_acks++;
                ack_log.push_back(1'b1);
                if (exp_d.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_d_ack: got d_ack=1 required none");
                end else begin
                    e = exp_d.pop_front();
                    if (e.chk) chk64("d_rdata", d_rdata, e.data);
                end
            end
        end
    end

    task automatic freq(input logic [63:0] addr, input logic [63:0] exp, input bit chk_bus);
        int n;
        bit seen;
        exp_i.push_back('{data: exp, chk: 1'b1});
        if_addr = addr;
        if_req  = 1'b1;
        n = 0;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            n++;
            if (if_ack) break;
            if (chk_bus && mem_req && !seen) begin
                seen = 1'b1;
                chk64("fetch_mem_addr", mem_addr, addr);
                chk1("fetch_mem_we", mem_we, 1'b0);
            end
            if (n > 300) begin
                checks++; errors++;
                $display("FAIL fetch_wait: got no if_ack in 300 cycles required ack");
                break;
            end
        end
        lat_i_last = n;
        @(posedge clk);
        #1;
        if_req = 1'b0;
    endtask

    task automatic dreq(input bit we, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [63:0] exp, input bit chk_data, input bit chk_bus,
                        input bit toggle);
        int n;
        bit seen;
        exp_d.push_back('{data: exp, chk: chk_data});
        d_we    = we;
        d_addr  = addr;
        d_wdata = wdata;
        d_req   = 1'b1;
        n = 0;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            n++;
            if (d_ack) break;
            if (chk_bus && mem_req && !seen) begin
                seen = 1'b1;
                chk64("data_mem_addr", mem_addr, addr);
                chk1("data_mem_we", mem_we, we);
                if (we) chk64("data_mem_wdata", mem_wdata, wdata);
            end
            if (toggle && mem_req) begin
                chk64("held_mem_addr", mem_addr, addr);
                chk1("held_mem_we", mem_we, we);
                d_addr  = d_addr ^ 64'hFF8;
                d_we    = ~d_we;
                d_wdata = ~d_wdata;
            end
            if (n > 300) begin
                checks++; errors++;
                $display("FAIL data_wait: got no d_ack in 300 cycles required ack");
                break;
            end
        end
        lat_d_last = n;
        @(posedge clk);
        #1;
        d_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] ordv;
        int a0, r0;
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        rdy_spur = 1'b0;
        @(negedge clk);
        chk1("rst_mem_req", mem_req, 1'b0);
        chk64("rst_mem_addr", mem_addr, 64'h0);
        chk1("rst_if_ack", if_ack, 1'b0);
        chk1("rst_d_ack", d_ack, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_stall", stall, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Lone fetch
        mem_lat = 2;
        freq(64'h40, 64'h00500093, 1'b1);
        chk64("fetch_latency", 64'(lat_i_last), 64'd4);
        @(negedge clk);
        chk1("fetch_stall_after", stall, 1'b0);
        chk1("fetch_ack_one_pulse", if_ack, 1'b0);
        @(posedge clk);
        #1;

        // Store then load
        dreq(1'b1, 64'h100, 64'hDEAD, 64'h0, 1'b0, 1'b1, 1'b0);
        mem_lat = 1;
        dreq(1'b0, 64'h100, 64'h0, 64'hDEAD, 1'b1, 1'b1, 1'b0);
        chk64("load_min_latency", 64'(lat_d_last), 64'd3);
        mem_lat = 2;

        // Simultaneous request: data first
        ack_log.delete();
        fork
            freq(64'h80, 64'hF00D, 1'b0);
            dreq(1'b0, RUN_ADDR[1], 64'h0, RUN_DATA[1], 1'b1, 1'b0, 1'b0);
        join
        ordv = '0;
        foreach (ack_log[i]) ordv = {ordv[6:0], ack_log[i]};
        chk64("contend_count", 64'(ack_log.size()), 64'd2);
        chk64("contend_order", 64'(ordv), 64'h02);

        // Data held for five grants: fetch goes after the fourth
        ack_log.delete();
        fork
            freq(64'h80, 64'hF00D, 1'b0);
            begin
                for (int k = 0; k < 5; k++)
                    dreq(1'b0, RUN_ADDR[k], 64'h0, RUN_DATA[k], 1'b1, 1'b0, 1'b0);
            end
        join
        ordv = '0;
        foreach (ack_log[i]) ordv = {ordv[6:0], ack_log[i]};
        chk64("run_count", 64'(ack_log.size()), 64'd6);
        chk64("run_order", 64'(ordv), 64'h3D);

        // Timeout
        mem_dead = 1'b1;
        r0 = req_hi;
        dreq(1'b0, 64'h300, 64'h0, 64'h0, 1'b1, 1'b1, 1'b0);
        chk64("timeout_req_cycles", 64'(req_hi - r0), 64'd8);
        chk64("timeout_latency", 64'(lat_d_last), 64'd10);
        chk1("timeout_err", err, 1'b1);
        mem_dead = 1'b0;
        freq(64'h40, 64'h00500093, 1'b1);
        chk64("after_timeout_latency", 64'(lat_i_last), 64'd4);
        chk1("err_sticky", err, 1'b1);

        // Spurious mem_ready in IDLE
        a0 = n_acks;
        rdy_spur = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk1("spur_mem_req", mem_req, 1'b0);
        end
        @(posedge clk);
        #1;
        rdy_spur = 1'b0;
        @(negedge clk);
        chk64("spur_no_ack", 64'(n_acks - a0), 64'd0);
        @(posedge clk);
        #1;

        // Requester inputs toggling mid-transaction
        mem_lat = 4;
        dreq(1'b0, RUN_ADDR[0], 64'h0, RUN_DATA[0], 1'b1, 1'b1, 1'b1);

        // Reset in the middle of BUSY_D
        mem_lat = 50;
        a0 = n_acks;
        d_we = 1'b0; d_addr = 64'h100; d_req = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk1("rst_pre_busy", mem_req, 1'b1);
        reset = 1'b1;
        #1;
        chk1("rst_mid_mem_req", mem_req, 1'b0);
        chk64("rst_mid_mem_addr", mem_addr, 64'h0);
        chk1("rst_mid_err", err, 1'b0);
        chk64("rst_mid_if_rdata", if_rdata, 64'h0);
        chk1("rst_mid_d_ack", d_ack, 1'b0);
        d_req = 1'b0;
        mem_lat = 2;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk64("rst_no_ack", 64'(n_acks - a0), 64'd0);
        @(posedge clk);
        #1;
        freq(64'h40, 64'h00500093, 1'b1);
        chk64("post_reset_latency", 64'(lat_i_last), 64'd4);

        @(negedge clk);
        chk64("exp_i_drained", 64'(exp_i.size()), 64'd0);
        chk64("exp_d_drained", 64'(exp_d.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
